// File: rtl/ptw_axi_responder_pkg.sv
// ptw_axi_responder_pkg: shared walker state encodings, port ids and fixed AXI read constants
package ptw_axi_responder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RET  = 2'd3
    } ptw_state_t;
    localparam logic [7:0] AXI_ARLEN   = 8'd0;
    localparam logic [2:0] AXI_ARSIZE  = 3'd3;
    localparam logic [1:0] AXI_ARBURST = 2'b01;
    localparam logic       PORT_ITLB   = 1'b0;
    localparam logic       PORT_DTLB   = 1'b1;
endpackage

// File: rtl/ptw_req_slot.sv
// ptw_req_slot: single pending walk-read request (valid bit plus PTE address) for one TLB port
module ptw_req_slot
    import ptw_axi_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_busy,
    input  logic                  i_grant,
    output logic                  o_pending,
    output logic [ADDR_WIDTH-1:0] o_addr
);
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_addr;
    // capture a request only when neither pending nor in flight; clear when granted
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end else if (i_req && !r_pending && !i_busy) begin
            r_pending <= 1'b1;
            r_addr    <= i_addr;
        end
    end
    assign o_pending = r_pending;
    assign o_addr    = r_addr;
endmodule

// File: rtl/ptw_axi_responder.sv
// ptw_axi_responder: arbitrates ITLB/DTLB page-walk reads onto a single-beat AXI read master
module ptw_axi_responder
    import ptw_axi_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ITLB_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
    input  logic                  DTLB_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
    output logic                  ITLB_DATA_VALID,
    output logic [DATA_WIDTH-1:0] ITLB_DATA,
    output logic                  ITLB_ERR,
    output logic                  DTLB_DATA_VALID,
    output logic [DATA_WIDTH-1:0] DTLB_DATA,
    output logic                  DTLB_ERR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]            M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    input  logic                  M_RVALID,
    output logic                  M_RREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST
);
    ptw_state_t            r_state;
    ptw_state_t            w_next;
    logic                  r_last;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_rready;
    logic                  r_i_dv;
    logic                  r_d_dv;
    logic                  r_i_err;
    logic                  r_d_err;
    logic [DATA_WIDTH-1:0] r_i_data;
    logic [DATA_WIDTH-1:0] r_d_data;
    logic                  w_i_pend;
    logic                  w_d_pend;
    logic [ADDR_WIDTH-1:0] w_i_addr;
    logic [ADDR_WIDTH-1:0] w_d_addr;
    logic                  w_any;
    logic                  w_pick_d;
    logic                  w_take;
    logic                  w_ar_hs;
    logic                  w_r_beat;
    logic                  w_inflight;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_rerr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_rlast;

    assign w_any          = w_i_pend | w_d_pend;
    assign w_pick_d       = w_d_pend & (~w_i_pend | (r_last == PORT_ITLB));
    assign w_take         = (r_state == ST_IDLE) & w_any;
    assign w_ar_hs        = (r_state == ST_AR) & r_arvalid & M_ARREADY;
    assign w_r_beat       = (r_state == ST_R) & M_RVALID;
    assign w_inflight     = (r_state == ST_AR) | ((r_state == ST_R) & ~M_RVALID);
    assign w_gnt_addr     = w_pick_d ? w_d_addr : w_i_addr;
    assign w_rerr         = |M_RRESP;
    assign w_rdata        = w_rerr ? '0 : M_RDATA;
    assign w_unused_rlast = M_RLAST;

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_itlb_slot (
        .CLK       (CLK),
        .RST       (RST),
        .i_req     (ITLB_ADDR_VALID),
        .i_addr    (ITLB_ADDR),
        .i_busy    (w_inflight & (r_last == PORT_ITLB)),
        .i_grant   (w_take & ~w_pick_d),
        .o_pending (w_i_pend),
        .o_addr    (w_i_addr)
    );

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_dtlb_slot (
        .CLK       (CLK),
        .RST       (RST),
        .i_req     (DTLB_ADDR_VALID),
        .i_addr    (DTLB_ADDR),
        .i_busy    (w_inflight & (r_last == PORT_DTLB)),
        .i_grant   (w_take & w_pick_d),
        .o_pending (w_d_pend),
        .o_addr    (w_d_addr)
    );

    // walker state register
    always_ff @(posedge CLK) begin
        r_state <= RST ? ST_IDLE : w_next;
    end

    // next-state: grant, address handshake, single data beat, one-cycle return
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_any ? ST_AR : ST_IDLE;
            ST_AR:   w_next = w_ar_hs ? ST_R : ST_AR;
            ST_R:    w_next = M_RVALID ? ST_RET : ST_R;
            ST_RET:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // AXI request/response registers and per-port return pulses; last grant doubles as the owner
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last    <= PORT_ITLB;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
            r_i_dv    <= 1'b0;
            r_d_dv    <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_err   <= 1'b0;
            r_i_data  <= '0;
            r_d_data  <= '0;
        end else begin
            r_i_dv  <= 1'b0;
            r_d_dv  <= 1'b0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
            if (w_take) begin
                r_last    <= w_pick_d;
                r_araddr  <= {w_gnt_addr[ADDR_WIDTH-1:3], 3'b000};
                r_arvalid <= 1'b1;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end
            if (w_r_beat) begin
                r_rready <= 1'b0;
                if (r_last == PORT_DTLB) begin
                    r_d_dv   <= 1'b1;
                    r_d_err  <= w_rerr;
                    r_d_data <= w_rdata;
                end else begin
                    r_i_dv   <= 1'b1;
                    r_i_err  <= w_rerr;
                    r_i_data <= w_rdata;
                end
            end
        end
    end

    assign M_ARVALID       = r_arvalid;
    assign M_ARADDR        = r_araddr;
    assign M_ARLEN         = AXI_ARLEN;
    assign M_ARSIZE        = AXI_ARSIZE;
    assign M_ARBURST       = AXI_ARBURST;
    assign M_RREADY        = r_rready;
    assign ITLB_DATA_VALID = r_i_dv;
    assign ITLB_DATA       = r_i_data;
    assign ITLB_ERR        = r_i_err;
    assign DTLB_DATA_VALID = r_d_dv;
    assign DTLB_DATA       = r_d_data;
    assign DTLB_ERR        = r_d_err;
endmodule

// File: tb/tb_ptw_axi_responder.sv
// tb_ptw_axi_responder: directed scoreboard bench with a behavioural single-beat AXI slave
module tb_ptw_axi_responder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ITLB_ADDR_VALID = 1'b0;
    logic [63:0] ITLB_ADDR = '0;
    logic        DTLB_ADDR_VALID = 1'b0;
    logic [63:0] DTLB_ADDR = '0;
    logic        ITLB_DATA_VALID, DTLB_DATA_VALID, ITLB_ERR, DTLB_ERR;
    logic [63:0] ITLB_DATA, DTLB_DATA;
    logic        M_ARVALID, M_RREADY;
    logic        M_ARREADY;
    logic [63:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_RVALID;
    logic [63:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST;

    typedef struct packed {
        logic        port;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    int          ar_count = 0;
    int          ar_stall = 0;
    logic        ovr_en = 1'b0;
    logic [63:0] ovr_data = '0;
    logic [1:0]  ovr_resp = '0;
    logic        s_hs, s_rb;
    logic [63:0] s_addr;

    ptw_axi_responder dut (
        .CLK(CLK), .RST(RST),
        .ITLB_ADDR_VALID(ITLB_ADDR_VALID), .ITLB_ADDR(ITLB_ADDR),
        .DTLB_ADDR_VALID(DTLB_ADDR_VALID), .DTLB_ADDR(DTLB_ADDR),
        .ITLB_DATA_VALID(ITLB_DATA_VALID), .ITLB_DATA(ITLB_DATA), .ITLB_ERR(ITLB_ERR),
        .DTLB_DATA_VALID(DTLB_DATA_VALID), .DTLB_DATA(DTLB_DATA), .DTLB_ERR(DTLB_ERR),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a & ~64'h7) ^ 64'h5A5A_0000_0000_00CF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic port, input logic [63:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic req(input logic d, input logic i, input logic [63:0] da, input logic [63:0] ia);
        @(posedge CLK); #1;
        DTLB_ADDR_VALID = d;
        DTLB_ADDR       = da;
        ITLB_ADDR_VALID = i;
        ITLB_ADDR       = ia;
        @(posedge CLK); #1;
        DTLB_ADDR_VALID = 1'b0;
        ITLB_ADDR_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge CLK);
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
        repeat (6) @(negedge CLK);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_arvalid"}, 64'(M_ARVALID), 64'd0);
        chk({tag, "_rready"}, 64'(M_RREADY), 64'd0);
        chk({tag, "_i_dv"}, 64'(ITLB_DATA_VALID), 64'd0);
        chk({tag, "_d_dv"}, 64'(DTLB_DATA_VALID), 64'd0);
        chk({tag, "_i_err"}, 64'(ITLB_ERR), 64'd0);
        chk({tag, "_d_err"}, 64'(DTLB_ERR), 64'd0);
        chk({tag, "_i_data"}, ITLB_DATA, 64'd0);
        chk({tag, "_d_data"}, DTLB_DATA, 64'd0);
        chk({tag, "_araddr"}, M_ARADDR, 64'd0);
    endtask

    // zero-wait single-beat slave with optional ARREADY stall and response override
    initial begin
        M_ARREADY = 1'b1;
        M_RVALID  = 1'b0;
        M_RDATA   = '0;
        M_RRESP   = '0;
        M_RLAST   = 1'b0;
        forever begin
            @(negedge CLK);
            s_hs   = M_ARVALID && M_ARREADY && !RST;
            s_rb   = M_RVALID && M_RREADY;
            s_addr = M_ARADDR;
            if (s_hs) ar_count++;
            @(posedge CLK); #1;
            if (s_rb || RST) M_RVALID = 1'b0;
            if (s_hs && !RST) begin
                M_RVALID = 1'b1;
                M_RDATA  = ovr_en ? ovr_data : mem_fn(s_addr);
                M_RRESP  = ovr_en ? ovr_resp : 2'b00;
                M_RLAST  = s_addr[3];
            end
            M_ARREADY = !(M_ARVALID && ar_stall > 0);
            if (M_ARVALID && ar_stall > 0) ar_stall--;
        end
    end

    // return monitor: every DATA_VALID pulse is matched against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (ITLB_DATA_VALID) i_cnt++;
            if (DTLB_DATA_VALID) d_cnt++;
            if (ITLB_DATA_VALID || DTLB_DATA_VALID) begin
                chk("dv_expected", 64'(sb.size() != 0), 64'd1);
                chk("dv_one_port", 64'(ITLB_DATA_VALID && DTLB_DATA_VALID), 64'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("dv_port", 64'(DTLB_DATA_VALID), 64'(e.port));
                    chk("dv_data", e.port ? DTLB_DATA : ITLB_DATA, e.data);
                    chk("dv_err", 64'(e.port ? DTLB_ERR : ITLB_ERR), 64'(e.err));
                    chk("dv_other_err", 64'(e.port ? ITLB_ERR : DTLB_ERR), 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2;
        repeat (3) @(negedge CLK);
        check_reset("reset");
        chk("arlen", 64'(M_ARLEN), 64'd0);
        chk("arsize", 64'(M_ARSIZE), 64'd3);
        chk("arburst", 64'(M_ARBURST), 64'd1);
        @(posedge CLK); #1;
        RST = 1'b0;

        // simultaneous pair from reset: last grant is ITLB, so DTLB first
        push(1'b1, mem_fn(64'h1000_0040), 1'b0);
        push(1'b0, mem_fn(64'h2000_0088), 1'b0);
        req(1'b1, 1'b1, 64'h1000_0040, 64'h2000_0088);
        drain("pair_a");

        // single DTLB, zero-wait latency N+2/N+3/N+4 and address alignment
        ovr_en   = 1'b1;
        ovr_data = 64'h0000_0000_2000_00CF;
        ovr_resp = 2'b00;
        c0 = i_cnt;
        push(1'b1, 64'h0000_0000_2000_00CF, 1'b0);
        req(1'b1, 1'b0, 64'h8000_1004, 64'h0);
        @(negedge CLK);
        chk("lat_n1_arvalid", 64'(M_ARVALID), 64'd0);
        @(negedge CLK);
        chk("lat_n2_arvalid", 64'(M_ARVALID), 64'd1);
        chk("lat_n2_araddr", M_ARADDR, 64'h8000_1000);
        @(negedge CLK);
        chk("lat_n3_rready", 64'(M_RREADY), 64'd1);
        chk("lat_n3_arvalid", 64'(M_ARVALID), 64'd0);
        chk("lat_n3_d_dv", 64'(DTLB_DATA_VALID), 64'd0);
        @(negedge CLK);
        chk("lat_n4_d_dv", 64'(DTLB_DATA_VALID), 64'd1);
        chk("lat_n4_d_data", DTLB_DATA, 64'h2000_00CF);
        chk("lat_n4_i_dv", 64'(ITLB_DATA_VALID), 64'd0);
        @(negedge CLK);
        chk("lat_n5_d_dv", 64'(DTLB_DATA_VALID), 64'd0);
        chk("lat_n5_d_hold", DTLB_DATA, 64'h2000_00CF);
        ovr_en = 1'b0;
        drain("single_d");
        chk("single_d_no_itlb", 64'(i_cnt - c0), 64'd0);

        // last grant is now DTLB, so the next simultaneous pair serves ITLB first
        push(1'b0, mem_fn(64'h3000_0010), 1'b0);
        push(1'b1, mem_fn(64'h4000_0018), 1'b0);
        req(1'b1, 1'b1, 64'h4000_0018, 64'h3000_0010);
        drain("pair_b");

        // ARREADY stalled for 5 cycles: request held stable, one handshake
        c0 = ar_count;
        ar_stall = 5;
        push(1'b0, mem_fn(64'h5000_0237), 1'b0);
        req(1'b0, 1'b1, 64'h0, 64'h5000_0237);
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("stall_arvalid", 64'(M_ARVALID), 64'd1);
            chk("stall_araddr", M_ARADDR, 64'h5000_0230);
            chk("stall_arready", 64'(M_ARREADY), 64'd0);
        end
        @(negedge CLK);
        chk("stall_release_arvalid", 64'(M_ARVALID), 64'd1);
        @(negedge CLK);
        chk("stall_post_arvalid", 64'(M_ARVALID), 64'd0);
        drain("stall");
        chk("stall_one_hs", 64'(ar_count - c0), 64'd1);

        // error response: DATA forced to 0, ERR pulsed once
        ovr_en   = 1'b1;
        ovr_data = 64'hFFFF;
        ovr_resp = 2'b10;
        c0 = d_cnt;
        push(1'b1, 64'h0, 1'b1);
        req(1'b1, 1'b0, 64'h6000_0008, 64'h0);
        drain("err");
        ovr_en = 1'b0;
        chk("err_one_pulse", 64'(d_cnt - c0), 64'd1);

        // second ITLB pulse while its transaction is in AR is dropped
        c0 = ar_count;
        c1 = i_cnt;
        push(1'b0, mem_fn(64'h7000_0100), 1'b0);
        req(1'b0, 1'b1, 64'h0, 64'h7000_0100);
        req(1'b0, 1'b1, 64'h0, 64'h7000_0200);
        drain("dup");
        chk("dup_one_ar", 64'(ar_count - c0), 64'd1);
        chk("dup_one_dv", 64'(i_cnt - c1), 64'd1);

        // ITLB re-request on the R-to-RET cycle (N+3) is captured and served
        c1 = i_cnt;
        push(1'b0, mem_fn(64'h7100_0000), 1'b0);
        push(1'b0, mem_fn(64'h7100_0040), 1'b0);
        req(1'b0, 1'b1, 64'h0, 64'h7100_0000);
        @(posedge CLK); #1;
        req(1'b0, 1'b1, 64'h0, 64'h7100_0040);
        drain("rret");
        chk("rret_two_dv", 64'(i_cnt - c1), 64'd2);

        // ITLB re-request during RET (N+4) is captured and served
        c1 = i_cnt;
        push(1'b0, mem_fn(64'h7200_0000), 1'b0);
        push(1'b0, mem_fn(64'h7200_0078), 1'b0);
        req(1'b0, 1'b1, 64'h0, 64'h7200_0000);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        req(1'b0, 1'b1, 64'h0, 64'h7200_0078);
        drain("ret");
        chk("ret_two_dv", 64'(i_cnt - c1), 64'd2);

        // reset while in R abandons the transaction without a return pulse
        c1 = i_cnt;
        c2 = d_cnt;
        req(1'b1, 1'b0, 64'h9000_0000, 64'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_in_r_rready", 64'(M_RREADY), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_reset("rst_in_r");
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("rst_in_r_no_dv", 64'((i_cnt - c1) + (d_cnt - c2)), 64'd0);

        // last grant returns to ITLB after reset: DTLB wins the pair again
        push(1'b1, mem_fn(64'hA000_0020), 1'b0);
        push(1'b0, mem_fn(64'hB000_0028), 1'b0);
        req(1'b1, 1'b1, 64'hA000_0020, 64'hB000_0028);
        drain("pair_c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
